// File: rtl/tile_rom_server.sv
// Tile-ROM responder: serves 32-bit word requests as two 16-bit memory beats
// (high half first), with a one-entry last-fetch buffer for immediate repeats.
module tile_rom_server #(
  parameter int AW = 20,
  parameter int MW = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rom_req,
  input  logic [AW-1:0] i_rom_addr,
  output logic          o_rom_valid,
  output logic [31:0]   o_rom_data,
  output logic          o_mem_req,
  output logic [MW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [15:0]   i_mem_data,
  input  logic          i_flush
);

  typedef enum logic [2:0] {S_IDLE, S_RD_HI, S_GAP, S_RD_LO, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rom_valid, w_rom_valid_nxt;
  logic [31:0]   r_rom_data, w_rom_data_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  logic [MW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [AW-1:0] r_req_addr, w_req_addr_nxt;
  logic          r_abort, w_abort_nxt;
  logic          r_buf_vld;
  logic [AW-1:0] r_buf_addr;
  logic [31:0]   r_buf_data;
  logic          w_hit, w_buf_wr;

  assign w_hit = r_buf_vld && (i_rom_addr == r_buf_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rom_valid <= 1'b0;
      r_rom_data  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_req_addr  <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rom_valid <= w_rom_valid_nxt;
      r_rom_data  <= w_rom_data_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  // r_abort remembers that the requester let go mid-fetch, so the fetch
  // still lands in the buffer but is never presented.
  always_comb begin
    w_state_nxt     = r_state;
    w_rom_valid_nxt = r_rom_valid;
    w_rom_data_nxt  = r_rom_data;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_req_addr_nxt  = r_req_addr;
    w_abort_nxt     = r_abort;
    w_buf_wr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_abort_nxt = 1'b0;
        if (i_rom_req) begin
          if (w_hit) begin
            w_rom_data_nxt  = r_buf_data;
            w_rom_valid_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else begin
            w_req_addr_nxt = i_rom_addr;
            w_mem_addr_nxt = MW'({i_rom_addr, 1'b0});
            w_mem_req_nxt  = 1'b1;
            w_state_nxt    = S_RD_HI;
          end
        end
      end
      S_RD_HI: begin
        if (!i_rom_req) w_abort_nxt = 1'b1;
        if (i_mem_ack) begin
          w_rom_data_nxt[31:16] = i_mem_data;
          w_mem_req_nxt         = 1'b0;
          w_state_nxt           = S_GAP;
        end
      end
      S_GAP: begin
        if (!i_rom_req) w_abort_nxt = 1'b1;
        w_mem_addr_nxt = MW'({r_req_addr, 1'b1});
        w_mem_req_nxt  = 1'b1;
        w_state_nxt    = S_RD_LO;
      end
      S_RD_LO: begin
        if (i_mem_ack) begin
          w_rom_data_nxt[15:0] = i_mem_data;
          w_mem_req_nxt        = 1'b0;
          w_buf_wr             = 1'b1;
          if (r_abort || !i_rom_req) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_rom_valid_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end
        end else if (!i_rom_req) begin
          w_abort_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (!i_rom_req) begin
          w_rom_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flush takes priority over a same-cycle fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else begin
      if (i_flush)       r_buf_vld <= 1'b0;
      else if (w_buf_wr) r_buf_vld <= 1'b1;
      if (w_buf_wr) begin
        r_buf_addr <= r_req_addr;
        r_buf_data <= {r_rom_data[31:16], i_mem_data};
      end
    end
  end

  assign o_rom_valid = r_rom_valid;
  assign o_rom_data  = r_rom_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_tile_rom_server.sv
// Bench for tile_rom_server: directed scenarios plus a randomized request mix,
// checked against a memory function and a last-fetch buffer model.
module tb_tile_rom_server;
  localparam int AW = 20;
  localparam int MW = 21;

  logic          clk = 1'b0;
  logic          reset, rom_req, flush, mem_ack;
  logic [AW-1:0] rom_addr;
  logic          rom_valid, mem_req;
  logic [31:0]   rom_data;
  logic [MW-1:0] mem_addr;
  logic [15:0]   mem_data;

  int checks = 0;
  int errors = 0;
  int n_lat  = 2;
  bit spurious = 1'b0;
  logic [MW-1:0] addr_q[$];

  // Model of the last-fetch buffer
  bit            mb_vld = 1'b0;
  logic [AW-1:0] mb_addr = '0;

  int q0, cyc;
  bit saw;
  logic [AW-1:0] pool [4];

  always #5 clk = ~clk;

  tile_rom_server #(.AW(AW), .MW(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rom_req  (rom_req),
    .i_rom_addr (rom_addr),
    .o_rom_valid(rom_valid),
    .o_rom_data (rom_data),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .i_mem_ack  (mem_ack),
    .i_mem_data (mem_data),
    .i_flush    (flush)
  );

  function automatic logic [15:0] mem_word(input logic [MW-1:0] a);
    if (a == 21'h2468A) return 16'hABCD;
    if (a == 21'h2468B) return 16'h1234;
    return a[15:0] ^ 16'h5A3C ^ {a[20:16], 11'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory port: ack is driven n_lat cycles after mem_req is first seen
  // high, so the DUT samples it on the (n_lat+1)-th edge after the rise.
  initial begin : responder
    bit pending, last_req;
    int cnt;
    logic [MW-1:0] paddr;
    pending = 0; last_req = 0; cnt = 0; paddr = '0;
    mem_ack = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset) begin
        pending = 0; last_req = 0;
      end else begin
        if (mem_req && !last_req) begin
          pending = 1; cnt = 0; paddr = mem_addr;
          addr_q.push_back(mem_addr);
        end else if (pending) begin
          cnt++;
        end
        if (pending && cnt == n_lat) begin
          mem_ack = 1'b1; mem_data = mem_word(paddr); pending = 0;
        end
        if (spurious) begin
          mem_ack = 1'b1; mem_data = 16'hDEAD; spurious = 0;
        end
        last_req = mem_req;
      end
    end
  end

  // One full request: issue, measure latency, hold with a wandering address,
  // drop. cyc counts cycles until rom_valid is visible: a hit loads on the
  // sampling edge (1), a miss loads on edge 2n+3 after it (2n+4).
  task automatic txn(input logic [AW-1:0] a, input bit fl);
    int c, qs, hold;
    bit hit, ok;
    logic [31:0] expd;
    hit  = mb_vld && (mb_addr == a);
    expd = {mem_word({a, 1'b0}), mem_word({a, 1'b1})};
    qs   = addr_q.size();
    rom_addr = a; rom_req = 1'b1; flush = fl;
    c = 0;
    do begin @(negedge clk); c++; end while (!rom_valid && c < 60);
    chk("latency", c, hit ? 1 : 2*n_lat + 4);
    chk("rom_data", rom_data, expd);
    chk("mem_reads", addr_q.size() - qs, hit ? 0 : 2);
    if (!hit && addr_q.size() >= qs + 2) begin
      chk("addr_hi", addr_q[qs], {a, 1'b0});
      chk("addr_lo", addr_q[qs+1], {a, 1'b1});
    end
    if (fl) mb_vld = 1'b0;
    else begin mb_vld = 1'b1; mb_addr = a; end
    hold = $urandom_range(1, 3);
    ok = 1;
    repeat (hold) begin
      rom_addr = AW'($urandom);
      @(negedge clk);
      if (rom_valid !== 1'b1 || rom_data !== expd) ok = 0;
    end
    chk("hold_stable", ok, 1);
    chk("hold_no_read", addr_q.size() - qs, hit ? 0 : 2);
    rom_req = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("valid_drop", rom_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pool = '{20'h12345, 20'h0ABCD, 20'h00777, 20'hFFFFF};
    reset = 1'b1; rom_req = 1'b0; rom_addr = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rom_valid, 0);
    chk("rst_data", rom_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Miss, hit, flush then miss again
    n_lat = 2;
    txn(20'h12345, 1'b0);
    txn(20'h12345, 1'b0);
    flush = 1'b1; @(negedge clk); flush = 1'b0; mb_vld = 1'b0;
    txn(20'h12345, 1'b0);

    // Requester lets go during the first beat
    n_lat = 3;
    q0 = addr_q.size();
    rom_addr = 20'h0ABCD; rom_req = 1'b1;
    @(negedge clk);
    rom_req = 1'b0;
    saw = 0;
    repeat (2*n_lat + 8) begin @(negedge clk); if (rom_valid) saw = 1; end
    chk("abort_no_valid", saw, 0);
    chk("abort_reads", addr_q.size() - q0, 2);
    chk("abort_mem_idle", mem_req, 0);
    mb_vld = 1'b1; mb_addr = 20'h0ABCD;
    txn(20'h0ABCD, 1'b0);

    // Top of address space, then a stray ack while idle
    n_lat = 1;
    txn(20'hFFFFF, 1'b0);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_mem_req", mem_req, 0);
    chk("spur_valid", rom_valid, 0);
    chk("spur_data", rom_data, {mem_word(21'h1FFFFE), mem_word(21'h1FFFFF)});

    // Reset while between beats
    n_lat = 2;
    rom_addr = 20'h00777; rom_req = 1'b1;
    cyc = 0;
    while (!mem_req && cyc < 20) begin @(negedge clk); cyc++; end
    while (mem_req && cyc < 20) begin @(negedge clk); cyc++; end
    chk("gap_reached", cyc < 20, 1);
    reset = 1'b1; rom_req = 1'b0; mb_vld = 1'b0;
    @(negedge clk);
    chk("gap_rst_valid", rom_valid, 0);
    chk("gap_rst_data", rom_data, 0);
    chk("gap_rst_mem_req", mem_req, 0);
    chk("gap_rst_mem_addr", mem_addr, 0);
    reset = 1'b0; spurious = 1'b1;
    repeat (3) @(negedge clk);
    chk("late_ack_valid", rom_valid, 0);
    chk("late_ack_mem_req", mem_req, 0);
    txn(20'h00777, 1'b0);

    // Flush coincident with the buffer fill leaves it invalid
    txn(20'h55555, 1'b1);
    txn(20'h55555, 1'b0);

    // Randomized mix over a small address pool so hits occur
    for (int i = 0; i < 24; i++) begin
      n_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) begin
        flush = 1'b1; @(negedge clk); flush = 1'b0; mb_vld = 1'b0;
      end
      txn(pool[$urandom_range(0, 3)], $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
